spi_master: RTL and testbench

- SPI initiator that runs one 16-bit transaction against the SPI memory slave.
- Drives sclk_pin, cs_pin and mosi_pin, and samples miso_pin.
- Frame is 7-bit address, then R/W bit, then 8 data bits, all MSB first.
- Sits on the FPGA test harness side so the slave can be exercised from a host-side command interface (start/addr/rw/wdata in, rdata/done out).

---
 rtl/spi_master.sv | 157 +++++++++++++++
 tb/tb_spi_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator running one {addr, rw, data} frame, MSB first.
// Define SPI_MISO_SYNC_EN to add a two-flop miso synchronizer with delayed sampling.
`timescale 1ns/1ps
module spi_master #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam int unsigned FRAME_W = ADDR_W + 1 + DATA_W;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(ADDR_W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic                rw_q;
    logic                tc;
    logic                rise_now;
    logic                sample_en;
    logic                sample_bit;

    always_comb begin
        tc       = (div_cnt == DIV_LAST);
        rise_now = tc && ((state == SETUP) ||
                          (state == SHIFT && !sclk_pin && bit_cnt != BIT_LAST));
    end

`ifdef SPI_MISO_SYNC_EN
    logic miso_s1, miso_s2, rise_q, rise_qq;

    // Sampling two cycles after the rise lines up with miso_s2 holding the pre-rise value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            rise_q  <= 1'b0;
            rise_qq <= 1'b0;
        end else begin
            miso_s1 <= miso_pin;
            miso_s2 <= miso_s1;
            rise_q  <= rise_now;
            rise_qq <= rise_q;
        end
    end

    always_comb begin
        sample_en  = rise_qq;
        sample_bit = miso_s2;
    end
`else
    always_comb begin
        sample_en  = rise_now;
        sample_bit = miso_pin;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            sclk_pin <= 1'b0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || tc)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            if (sample_en)
                rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};

            if (rise_now) begin
                sclk_pin <= 1'b1;
                bit_cnt  <= bit_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr    <= {addr, rw, wdata};
                        rw_q     <= rw;
                        busy     <= 1'b1;
                        cs_pin   <= 1'b0;
                        mosi_pin <= addr[ADDR_W-1];
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tc)
                        state <= SHIFT;
                end
                SHIFT: begin
                    // The last bit keeps a full low half-period before HOLD so the frame spans 16 whole sclk periods.
                    if (tc && sclk_pin) begin
                        sclk_pin <= 1'b0;
                        if (bit_cnt < BIT_LAST) begin
                            tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
                            mosi_pin <= (rw_q && bit_cnt >= DATA_FIRST) ? 1'b0 : tx_sr[FRAME_W-2];
                        end
                    end else if (tc && bit_cnt == BIT_LAST) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tc) begin
                        cs_pin   <= 1'b1;
                        mosi_pin <= 1'b0;
                        done     <= 1'b1;
                        if (rw_q)
                            rdata <= rx_sr;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master against a behavioural SPI slave.
// Instance 0 runs with CLK_DIV=4, instance 1 with CLK_DIV=6.
`timescale 1ns/1ps
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       start_w  [2] = '{1'b0, 1'b0};
    logic       busy_w   [2];
    logic       done_w   [2];
    logic [7:0] rdata_w  [2];
    logic       sclk_w   [2];
    logic       cs_w     [2];
    logic       mosi_w   [2];
    logic       miso_w   [2] = '{1'b0, 1'b0};

    logic [7:0]  slave_byte [2] = '{8'h00, 8'h00};
    int          rises      [2] = '{0, 0};
    logic [15:0] mosi_cap   [2] = '{16'h0, 16'h0};
    int          done_cnt   [2] = '{0, 0};
    int          cs_run     [2] = '{0, 0};
    int          last_gap   [2] = '{0, 0};
    logic        sclk_prev  [2] = '{1'b0, 1'b0};
    logic        cs_prev    [2] = '{1'b1, 1'b1};

    int errors = 0;
    int checks = 0;

    spi_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_w[0]), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .sclk_pin(sclk_w[0]), .cs_pin(cs_w[0]), .mosi_pin(mosi_w[0]), .miso_pin(miso_w[0])
    );

    spi_master #(.CLK_DIV(6), .ADDR_W(7), .DATA_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_w[1]), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .sclk_pin(sclk_w[1]), .cs_pin(cs_w[1]), .mosi_pin(mosi_w[1]), .miso_pin(miso_w[1])
    );

    // Slave model: captures mosi on rising sclk, drives data bits 8..15 after falling sclk.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cs_prev[g] && !cs_w[g]) begin
                rises[g]    = 0;
                mosi_cap[g] = 16'h0;
                last_gap[g] = cs_run[g];
            end
            if (cs_w[g]) cs_run[g]++;
            else         cs_run[g] = 0;
            if (!sclk_prev[g] && sclk_w[g]) begin
                mosi_cap[g] = {mosi_cap[g][14:0], mosi_w[g]};
                rises[g]++;
            end
            if (sclk_prev[g] && !sclk_w[g]) begin
                if (rises[g] >= 8 && rises[g] < 16) miso_w[g] = slave_byte[g][15 - rises[g]];
                else                                miso_w[g] = 1'b0;
            end
            if (done_w[g]) done_cnt[g]++;
            sclk_prev[g] = sclk_w[g];
            cs_prev[g]   = cs_w[g];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // n counts clk edges after the accepting edge; poke_at pulses start mid-frame.
    task automatic run_txn(input int g, input logic r, input logic [6:0] a, input logic [7:0] w,
                           input int poke_at, output int done_at, output int idle_at,
                           output logic [7:0] rd);
        done_at = -1;
        idle_at = -1;
        rd      = 8'h00;
        rw = r; addr = a; wdata = w;
        start_w[g] = 1'b1;
        tick();
        check($sformatf("busy_after_accept_%0d", g), int'(busy_w[g]), 1);
        for (int n = 0; n < 1000; n++) begin
            if (n > 0) tick();
            start_w[g] = (n == poke_at);
            if (done_w[g] && done_at < 0) begin
                done_at = n;
                rd      = rdata_w[g];
            end
            if (!busy_w[g]) begin
                idle_at = n;
                break;
            end
        end
        start_w[g] = 1'b0;
    endtask

    initial begin
        int d_at, i_at, d1, d2, dc0;
        logic [7:0] rd;

        reset_n = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("rst_cs",    int'(cs_w[0]),    1);
        check("rst_sclk",  int'(sclk_w[0]),  0);
        check("rst_mosi",  int'(mosi_w[0]),  0);
        check("rst_busy",  int'(busy_w[0]),  0);
        check("rst_done",  int'(done_w[0]),  0);
        check("rst_rdata", int'(rdata_w[0]), 0);
        check("rst_rdata1", int'(rdata_w[1]), 0);

        // Write 0x2A <- 0xC3, with an ignored start pulse mid-frame.
        dc0 = done_cnt[0];
        run_txn(0, 1'b0, 7'h2A, 8'hC3, 50, d_at, i_at, rd);
        check("wr_done_at",  d_at, 136);
        check("wr_idle_at",  i_at, 140);
        check("wr_mosi",     int'(mosi_cap[0]), 16'h54C3);
        check("wr_rises",    rises[0], 16);
        check("wr_rdata",    int'(rdata_w[0]), 0);
        check("wr_done_cnt", done_cnt[0] - dc0, 1);
        repeat (5) tick();
        check("wr_no_requeue", int'(busy_w[0]), 0);

        // Read 0x2A, slave returns 0x5A; wdata must not reach mosi.
        slave_byte[0] = 8'h5A;
        run_txn(0, 1'b1, 7'h2A, 8'hFF, -1, d_at, i_at, rd);
        check("rd_done_at", d_at, 136);
        check("rd_rdata_at_done", int'(rd), 8'h5A);
        check("rd_mosi",    int'(mosi_cap[0]), 16'h5500);
        check("rd_rdata_hold", int'(rdata_w[0]), 8'h5A);

        // Back-to-back: start held high across two frames.
        dc0 = done_cnt[0];
        d1 = -1; d2 = -1;
        rw = 1'b0; addr = 7'h11; wdata = 8'h22;
        start_w[0] = 1'b1;
        tick();
        for (int n = 0; n < 400; n++) begin
            if (n > 0) tick();
            if (n == 200) start_w[0] = 1'b0;
            if (done_w[0]) begin
                if (d1 < 0) d1 = n;
                else        d2 = n;
            end
        end
        start_w[0] = 1'b0;
        check("b2b_done1",    d1, 136);
        check("b2b_done2",    d2, 277);
        check("b2b_done_cnt", done_cnt[0] - dc0, 2);
        check("b2b_cs_gap",   last_gap[0], 5);
        check("b2b_idle",     int'(busy_w[0]), 0);
        check("b2b_rdata",    int'(rdata_w[0]), 8'h5A);

        // Reset after the 5th rising sclk edge of a read.
        dc0 = done_cnt[0];
        rw = 1'b1; addr = 7'h2A;
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        for (int n = 0; n < 200 && rises[0] < 5; n++) tick();
        check("abort_rise5", rises[0], 5);
        reset_n = 1'b0;
        tick();
        check("abort_cs",    int'(cs_w[0]),   1);
        check("abort_sclk",  int'(sclk_w[0]), 0);
        check("abort_busy",  int'(busy_w[0]), 0);
        check("abort_rdata", int'(rdata_w[0]), 0);
        reset_n = 1'b1;
        repeat (4) tick();
        check("abort_no_done", done_cnt[0] - dc0, 0);
        slave_byte[0] = 8'h3C;
        run_txn(0, 1'b1, 7'h05, 8'h00, -1, d_at, i_at, rd);
        check("post_abort_done_at", d_at, 136);
        check("post_abort_rdata",   int'(rd), 8'h3C);
        check("post_abort_mosi",    int'(mosi_cap[0]), 16'h0B00);

        // CLK_DIV=6 instance reading 0xA5.
        slave_byte[1] = 8'hA5;
        run_txn(1, 1'b1, 7'h2A, 8'h00, -1, d_at, i_at, rd);
        check("div6_done_at", d_at, 204);
        check("div6_idle_at", i_at, 210);
        check("div6_rdata",   int'(rd), 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
